// File: rtl/spectrum_band_leveler_pkg.sv
// ---------------------------------------------------------------------------
// spectrum_band_leveler_pkg
//   Shared types for the spectrum band leveler and the beat detector that
//   consumes its output. The beat detector imports band_levels_t from here so
//   both sides agree on the packed 16 x 4-bit level layout.
//
//   Contents:
//     N_BANDS, LEVEL_W, LEVEL_MAX  band count and level width
//     level_t                      one 4-bit band level
//     band_levels_t                [15:0][3:0] level array, band 0 = lowest bins
//     band_idx_t                   index of one band
//     state_t                      leveler FSM states
//     decayLevel / maxLevel        peak-hold helpers
// ---------------------------------------------------------------------------
package spectrum_band_leveler_pkg;

  localparam int N_BANDS   = 16;
  localparam int LEVEL_W   = 4;
  localparam int LEVEL_MAX = (1 << LEVEL_W) - 1;

  typedef logic [LEVEL_W-1:0]                  level_t;
  typedef logic [N_BANDS-1:0][LEVEL_W-1:0]     band_levels_t;
  typedef logic [$clog2(N_BANDS)-1:0]          band_idx_t;

  typedef enum logic [1:0] {
    S_ACCUM   = 2'd0,
    S_QUANT   = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  // Held level after one frame of fall, saturating at zero.
  function automatic level_t decayLevel(input level_t held, input level_t step);
    return (held > step) ? level_t'(held - step) : '0;
  endfunction

  // Larger of two levels; a fresh peak always wins over the decaying value.
  function automatic level_t maxLevel(input level_t a, input level_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spectrum_band_leveler_quantizer.sv
// ---------------------------------------------------------------------------
// band_level_quantizer
//   Purely combinational log-level mapping of one band sum.
//   level = 0 when the sum is zero, otherwise the position of the most
//   significant set bit plus one, minus LEVEL_SHIFT, clamped to 0..LEVEL_MAX.
//
//   Ports:
//     sum_i    in   SUM_W    band sum to be mapped
//     level_o  out  LEVEL_W  resulting raw level (before peak-hold)
// ---------------------------------------------------------------------------
module band_level_quantizer
  import spectrum_band_leveler_pkg::*;
#(
  parameter int SUM_W       = 20,
  parameter int LEVEL_SHIFT = 4
) (
  input  logic [SUM_W-1:0] sum_i,
  output level_t           level_o
);

  int msbPos;
  int rawLevel;

  // Priority encoder scans upward so the last set bit seen is the msb; the
  // shifted result is then clamped into the level range. A zero sum has no
  // msb at all and is forced to level 0 rather than treated as bit 0.
  always_comb begin
    msbPos = 0;
    for (int b = 0; b < SUM_W; b++) begin
      if (sum_i[b]) begin
        msbPos = b;
      end
    end
    rawLevel = msbPos + 1 - LEVEL_SHIFT;
    if (sum_i == '0) begin
      level_o = '0;
    end else if (rawLevel < 0) begin
      level_o = '0;
    end else if (rawLevel > LEVEL_MAX) begin
      level_o = level_t'(LEVEL_MAX);
    end else begin
      level_o = level_t'(rawLevel);
    end
  end

endmodule

// File: rtl/spectrum_band_leveler.sv
// ---------------------------------------------------------------------------
// spectrum_band_leveler
//   Upstream feeder of the beat detector. Streams one frame of FFT magnitude
//   bins, sums them into 16 contiguous bands, converts each band sum into a
//   4-bit log level with peak-hold/decay and publishes the 16-level array once
//   per frame together with a one-cycle done pulse.
//
//   Ports:
//     i_clk         in   1             system clock
//     i_rst_n       in   1             asynchronous reset, active-low
//     i_bin_valid   in   1             bin magnitude valid
//     i_bin_mag     in   MAG_W         unsigned bin magnitude
//     i_bin_last    in   1             final bin of frame (qualified by handshake)
//     o_bin_ready   out  1             a bin is accepted this cycle if valid
//     o_level       out  band_levels_t published levels, band 0 = lowest bins
//     o_frame_done  out  1             one-cycle pulse while fresh o_level is shown
//
//   Frame flow: S_ACCUM takes bins until the last one, S_QUANT spends one
//   cycle per band updating the held levels, S_PUBLISH shows the result for a
//   single cycle before bins are accepted again.
// ---------------------------------------------------------------------------
module spectrum_band_leveler
  import spectrum_band_leveler_pkg::*;
#(
  parameter int N_BINS      = 256,
  parameter int MAG_W       = 16,
  parameter int LEVEL_SHIFT = 4,
  parameter int DECAY_STEP  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_bin_valid,
  input  logic [MAG_W-1:0] i_bin_mag,
  input  logic             i_bin_last,
  output logic             o_bin_ready,
  output band_levels_t     o_level,
  output logic             o_frame_done
);

  localparam int BPB   = N_BINS / N_BANDS;
  localparam int SUM_W = MAG_W + $clog2(BPB);
  localparam int IDX_W = $clog2(N_BINS);
  // A band of a single bin still needs a 1-bit position counter.
  localparam int POS_W = (BPB > 1) ? $clog2(BPB) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_BINS - 1);
  localparam logic [POS_W-1:0] LAST_POS   = POS_W'(BPB - 1);
  localparam band_idx_t        LAST_BAND  = band_idx_t'(N_BANDS - 1);
  localparam level_t           DECAY      = level_t'(DECAY_STEP);

  state_t           state_q;
  logic [IDX_W-1:0] binIdx_q;
  logic [POS_W-1:0] bandPos_q;
  band_idx_t        band_q;
  band_idx_t        quantIdx_q;
  logic [SUM_W-1:0] accSum_q;
  logic [SUM_W-1:0] accSum_d;
  logic [SUM_W-1:0] bandSum_q [N_BANDS];
  band_levels_t     held_q;
  band_levels_t     held_d;
  band_levels_t     level_q;
  logic             frameDone_q;

  logic             binAccept;
  logic             bandEnd;
  logic             frameEnd;
  level_t           rawLevel;
  level_t           heldLevel_d;

  band_level_quantizer #(
    .SUM_W       (SUM_W),
    .LEVEL_SHIFT (LEVEL_SHIFT)
  ) u_quantizer (
    .sum_i   (bandSum_q[quantIdx_q]),
    .level_o (rawLevel)
  );

  // Handshake and band/frame boundary detection for the bin being offered,
  // plus the running sum including it. The accumulator is wide enough for a
  // full band of maximum magnitudes, so the add never wraps.
  always_comb begin
    binAccept = i_bin_valid && (state_q == S_ACCUM);
    accSum_d  = accSum_q + SUM_W'(i_bin_mag);
    bandEnd   = (bandPos_q == LAST_POS) || i_bin_last;
    frameEnd  = i_bin_last || (binIdx_q == LAST_IDX);
  end

  // Peak-hold update for the band being quantized this cycle. held_d is the
  // whole array with that one band replaced, so the final quantize cycle can
  // load o_level with the band-15 result that is being written simultaneously.
  always_comb begin
    heldLevel_d         = maxLevel(rawLevel, decayLevel(held_q[quantIdx_q], DECAY));
    held_d              = held_q;
    held_d[quantIdx_q]  = heldLevel_d;
  end

  // Frame FSM together with the datapath registers it sequences. Each band
  // sum is cleared right after it has been quantized, so a frame that ends
  // early with i_bin_last leaves the unreached bands at zero for the next
  // quantize pass without any extra clearing step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_ACCUM;
      binIdx_q    <= '0;
      bandPos_q   <= '0;
      band_q      <= '0;
      quantIdx_q  <= '0;
      accSum_q    <= '0;
      held_q      <= '0;
      level_q     <= '0;
      frameDone_q <= 1'b0;
      for (int b = 0; b < N_BANDS; b++) begin
        bandSum_q[b] <= '0;
      end
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (binAccept) begin
            if (bandEnd) begin
              bandSum_q[band_q] <= accSum_d;
              accSum_q          <= '0;
              bandPos_q         <= '0;
              band_q            <= band_q + 1'b1;
            end else begin
              accSum_q          <= accSum_d;
              bandPos_q         <= bandPos_q + 1'b1;
            end
            if (frameEnd) begin
              binIdx_q   <= '0;
              bandPos_q  <= '0;
              band_q     <= '0;
              quantIdx_q <= '0;
              state_q    <= S_QUANT;
            end else begin
              binIdx_q   <= binIdx_q + 1'b1;
            end
          end
        end

        S_QUANT: begin
          held_q                <= held_d;
          bandSum_q[quantIdx_q] <= '0;
          if (quantIdx_q == LAST_BAND) begin
            level_q     <= held_d;
            frameDone_q <= 1'b1;
            state_q     <= S_PUBLISH;
          end else begin
            quantIdx_q  <= quantIdx_q + 1'b1;
          end
        end

        S_PUBLISH: begin
          frameDone_q <= 1'b0;
          state_q     <= S_ACCUM;
        end

        default: begin
          frameDone_q <= 1'b0;
          state_q     <= S_ACCUM;
        end
      endcase
    end
  end

  // Outputs come straight from registers; ready only depends on the state.
  always_comb begin
    o_bin_ready  = (state_q == S_ACCUM);
    o_level      = level_q;
    o_frame_done = frameDone_q;
  end

endmodule

// File: tb/tb_spectrum_band_leveler.sv
// ---------------------------------------------------------------------------
// tb_spectrum_band_leveler
//   Directed frames with hand-computed level arrays. The driver pushes the
//   expected array for each frame into a queue; a monitor pops it whenever
//   o_frame_done is seen and also checks done timing and the ready-low window.
// ---------------------------------------------------------------------------
module tb_spectrum_band_leveler;
  import spectrum_band_leveler_pkg::*;

  logic          clk;
  logic          i_rst_n;
  logic          i_bin_valid;
  logic [15:0]   i_bin_mag;
  logic          i_bin_last;
  logic          o_bin_ready;
  band_levels_t  o_level;
  logic          o_frame_done;

  int            assertCount = 0;
  int            failCount   = 0;
  int            cyc         = 0;
  int            lastAcceptCyc = 0;
  int            readyLowCount = 0;
  logic          prevDone = 1'b0;
  band_levels_t  expQ[$];
  logic [15:0]   frameBins [256];

  spectrum_band_leveler #(
    .N_BINS      (256),
    .MAG_W       (16),
    .LEVEL_SHIFT (4),
    .DECAY_STEP  (1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_bin_valid  (i_bin_valid),
    .i_bin_mag    (i_bin_mag),
    .i_bin_last   (i_bin_last),
    .o_bin_ready  (o_bin_ready),
    .o_level      (o_level),
    .o_frame_done (o_frame_done)
  );

  // 100 MHz clock and a free-running cycle counter for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  task automatic setBins(input int lo, input int hi, input logic [15:0] value);
    for (int i = 0; i < 256; i++) begin
      frameBins[i] = (i >= lo && i <= hi) ? value : 16'h0000;
    end
  endtask

  // Streams frameBins[0..len-1]; the final bin carries i_bin_last when
  // useLast is set. With holdValid the bus stays valid after the frame.
  task automatic applyStimulus(input int len, input band_levels_t expLevels,
                               input bit useLast, input bit holdValid);
    int waitCycles;
    expQ.push_back(expLevels);
    @(negedge clk);
    for (int i = 0; i < len; i++) begin
      i_bin_valid = 1'b1;
      i_bin_mag   = frameBins[i];
      i_bin_last  = useLast && (i == len - 1);
      waitCycles  = 0;
      while (!o_bin_ready && waitCycles < 200) begin
        @(negedge clk);
        waitCycles++;
      end
      if (!o_bin_ready) begin
        reportTimeout("binAccept");
        i = len;
      end else begin
        @(negedge clk);
      end
    end
    lastAcceptCyc = cyc;
    i_bin_last = 1'b0;
    if (holdValid) begin
      i_bin_mag = 16'hFFFF;
    end else begin
      i_bin_valid = 1'b0;
      i_bin_mag   = 16'h0000;
    end
  endtask

  task automatic waitIdle();
    int waitCycles;
    waitCycles = 0;
    while ((expQ.size() != 0 || !o_bin_ready) && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (expQ.size() != 0 || !o_bin_ready) begin
      reportTimeout("frameDone");
      expQ.delete();
    end
  endtask

  // Monitor: compares published levels against the scoreboard, checks the
  // done pulse lands 16 cycles after the last accept and lasts one cycle,
  // and checks ready stays low for exactly 17 cycles per frame.
  always @(negedge clk) begin
    if (!i_rst_n) begin
      readyLowCount = 0;
      prevDone      = 1'b0;
    end else begin
      if (prevDone) begin
        checkOutput("doneWidth", 64'(o_frame_done), 64'd0);
      end
      if (o_frame_done && !prevDone) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedDone", 64'(o_frame_done), 64'd0);
        end else begin
          checkOutput("levels", 64'(o_level), 64'(expQ.pop_front()));
        end
        checkOutput("doneLatency", 64'(cyc - lastAcceptCyc), 64'd16);
      end
      if (!o_bin_ready) begin
        readyLowCount++;
      end else if (readyLowCount != 0) begin
        checkOutput("readyLowCycles", 64'(readyLowCount), 64'd17);
        readyLowCount = 0;
      end
      prevDone = o_frame_done;
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    failCount++;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    band_levels_t e;
    int waitCycles;
    i_rst_n     = 1'b0;
    i_bin_valid = 1'b0;
    i_bin_mag   = 16'h0000;
    i_bin_last  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetLevel", 64'(o_level), 64'd0);
    checkOutput("resetReady", 64'(o_bin_ready), 64'd1);
    checkOutput("resetDone", 64'(o_frame_done), 64'd0);
    i_rst_n = 1'b1;

    $display("[TB] frame: bins 48..63 = 0x0100");
    setBins(48, 63, 16'h0100);
    e = '0; e[3] = 4'd9;
    applyStimulus(256, e, 1'b1, 1'b0);
    waitIdle();

    $display("[TB] reset asserted mid-frame");
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      i_bin_valid = 1'b1;
      i_bin_mag   = 16'hFFFF;
      @(negedge clk);
    end
    i_bin_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("midResetLevel", 64'(o_level), 64'd0);
    checkOutput("midResetReady", 64'(o_bin_ready), 64'd1);
    checkOutput("midResetDone", 64'(o_frame_done), 64'd0);
    @(negedge clk);
    i_rst_n = 1'b1;

    $display("[TB] frame after reset starts at band 0");
    setBins(48, 63, 16'h0100);
    e = '0; e[3] = 4'd9;
    applyStimulus(256, e, 1'b1, 1'b0);
    waitIdle();

    $display("[TB] zero frames: decay 9 -> 8 -> 7");
    setBins(0, -1, 16'h0000);
    e = '0; e[3] = 4'd8;
    applyStimulus(256, e, 1'b1, 1'b0);
    waitIdle();
    e = '0; e[3] = 4'd7;
    applyStimulus(256, e, 1'b0, 1'b0);
    waitIdle();

    $display("[TB] all bins 0xFFFF: every band clamps to 15");
    setBins(0, 255, 16'hFFFF);
    e = {16{4'd15}};
    applyStimulus(256, e, 1'b1, 1'b0);
    waitIdle();

    i_rst_n = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b1;

    $display("[TB] last at bin 40 with valid held through quantize");
    setBins(0, 40, 16'h0100);
    e = '0; e[0] = 4'd9; e[1] = 4'd9; e[2] = 4'd8;
    applyStimulus(41, e, 1'b1, 1'b1);
    waitCycles = 0;
    while (!o_frame_done && waitCycles < 40) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!o_frame_done) begin
      reportTimeout("holdValidDone");
    end
    i_bin_valid = 1'b0;
    i_bin_mag   = 16'h0000;
    waitIdle();

    $display("[TB] last at bin 0: band 0 only");
    setBins(0, 0, 16'hFFFF);
    e = '0; e[0] = 4'd12; e[1] = 4'd8; e[2] = 4'd7;
    applyStimulus(1, e, 1'b1, 1'b0);
    waitIdle();

    repeat (3) @(negedge clk);
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
